// File: rtl/mbp_update_gen_pkg.sv
// rtl/mbp_update_gen_pkg.sv - shared predictor metadata and update types for mbp_update_gen
package mbp_update_gen_pkg;

    localparam int unsigned VLEN = 32;

    typedef struct packed {
        logic lbp_valid;
        logic lbp_taken;
        logic gbp_valid;
        logic gbp_taken;
    } bp_metadata_t;

    localparam int unsigned META_W = $bits(bp_metadata_t);

    typedef struct packed {
        logic              valid;
        logic [VLEN-1:0]   pc;
        logic              taken;
        bp_metadata_t      metadata;
    } bht_update_t;

    localparam int unsigned UPDATE_W = $bits(bht_update_t);

    // One queued prediction: the pc it was made for and what each predictor said.
    typedef struct packed {
        logic [VLEN-1:0]   pc;
        bp_metadata_t      metadata;
    } meta_entry_t;

    localparam int unsigned ENTRY_W = $bits(meta_entry_t);

    function automatic bp_metadata_t mbp_meta_pack(
        input logic lbp_valid,
        input logic lbp_taken,
        input logic gbp_valid,
        input logic gbp_taken
    );
        bp_metadata_t m;
        m.lbp_valid = lbp_valid;
        m.lbp_taken = lbp_taken;
        m.gbp_valid = gbp_valid;
        m.gbp_taken = gbp_taken;
        return m;
    endfunction

endpackage

// File: rtl/mbp_meta_fifo.sv
// rtl/mbp_meta_fifo.sv - in-order FIFO of prediction metadata with wrap-bit pointers
module mbp_meta_fifo
    import mbp_update_gen_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_entry_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [AW:0]        count_o
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic               w_do_push;
    logic               w_do_pop;

    assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign count_o = r_wr_ptr - r_rd_ptr;
    assign head_o  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_do_push = push_i && !full_o && !clear_i;
    assign w_do_pop  = pop_i && !empty_o;

    // Clear wins over everything, so a pop that coincides with it just lands on the reset pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push && !rst_i) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_entry_i;
        end
    end

endmodule

// File: rtl/mbp_update_gen.sv
// rtl/mbp_update_gen.sv - pairs resolved branches with queued prediction metadata and issues
// one registered predictor update per in-order resolve.
module mbp_update_gen
    import mbp_update_gen_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                debug_mode_i,
    input  logic                push_valid_i,
    output logic                push_ready_o,
    input  logic [VLEN-1:0]     push_pc_i,
    input  logic [META_W-1:0]   push_metadata_i,
    input  logic                resolve_valid_i,
    input  logic [VLEN-1:0]     resolve_pc_i,
    input  logic                resolve_taken_i,
    input  logic                resolve_mispred_i,
    output logic [UPDATE_W-1:0] bht_update_o,
    output logic [CW-1:0]       count_o,
    output logic                error_o
);

    logic [ENTRY_W-1:0] w_head_raw;
    meta_entry_t        w_head;
    meta_entry_t        w_push_entry;
    logic               w_full;
    logic               w_empty;
    logic               w_pc_eq;
    logic               w_match;
    logic               w_mismatch;
    logic               w_error;
    logic               w_clear;
    logic               w_push;
    bht_update_t        r_update;
    logic               r_error;

    assign w_push_entry.pc       = push_pc_i;
    assign w_push_entry.metadata = bp_metadata_t'(push_metadata_i);
    assign w_head                = meta_entry_t'(w_head_raw);

    assign push_ready_o = !w_full;
    assign w_push       = push_valid_i && !w_full;

    assign w_pc_eq    = (w_head.pc == resolve_pc_i);
    assign w_match    = resolve_valid_i && !w_empty && w_pc_eq;
    assign w_mismatch = resolve_valid_i && !w_empty && !w_pc_eq;
    assign w_error    = resolve_valid_i && (w_empty || !w_pc_eq);

    // A mismatch or mispredict means everything behind the head is wrong-path state.
    assign w_clear = flush_i || w_mismatch || (w_match && resolve_mispred_i);

    mbp_meta_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (w_clear),
        .push_i       (w_push),
        .push_entry_i (w_push_entry),
        .pop_i        (w_match),
        .head_o       (w_head_raw),
        .full_o       (w_full),
        .empty_o      (w_empty),
        .count_o      (count_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_update <= '0;
            r_error  <= 1'b0;
        end else begin
            r_error <= w_error;
            if (w_match) begin
                r_update.valid    <= !debug_mode_i;
                r_update.pc       <= w_head.pc;
                r_update.taken    <= resolve_taken_i;
                r_update.metadata <= w_head.metadata;
            end else begin
                r_update <= '0;
            end
        end
    end

    assign bht_update_o = r_update;
    assign error_o      = r_error;

endmodule

// File: tb/tb_mbp_update_gen.sv
// tb/tb_mbp_update_gen.sv - randomized and directed checks of mbp_update_gen against a queue model
module tb_mbp_update_gen;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, debug_mode_i;
    logic        push_valid_i, push_ready_o;
    logic [31:0] push_pc_i;
    logic [3:0]  push_metadata_i;
    logic        resolve_valid_i, resolve_taken_i, resolve_mispred_i;
    logic [31:0] resolve_pc_i;
    logic [37:0] bht_update_o;
    logic [3:0]  count_o;
    logic        error_o;

    mbp_update_gen #(.DEPTH(DEPTH)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .flush_i           (flush_i),
        .debug_mode_i      (debug_mode_i),
        .push_valid_i      (push_valid_i),
        .push_ready_o      (push_ready_o),
        .push_pc_i         (push_pc_i),
        .push_metadata_i   (push_metadata_i),
        .resolve_valid_i   (resolve_valid_i),
        .resolve_pc_i      (resolve_pc_i),
        .resolve_taken_i   (resolve_taken_i),
        .resolve_mispred_i (resolve_mispred_i),
        .bht_update_o      (bht_update_o),
        .count_o           (count_o),
        .error_o           (error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  meta;
    } ent_t;

    ent_t        q[$];
    logic [37:0] exp_upd;
    logic        exp_err;
    logic        exp_rdy_pre, act_rdy_pre;
    int          vectors = 0;
    int          fails = 0;

    // Reference: queue of outstanding predictions; one call = one clock edge.
    task automatic cycle(input logic pv, input logic [31:0] ppc, input logic [3:0] pm,
                         input logic rv, input logic [31:0] rpc, input logic rt,
                         input logic rm, input logic fl, input logic dbg);
        logic clr;
        ent_t e;
        push_valid_i = pv; push_pc_i = ppc; push_metadata_i = pm;
        resolve_valid_i = rv; resolve_pc_i = rpc; resolve_taken_i = rt;
        resolve_mispred_i = rm; flush_i = fl; debug_mode_i = dbg;
        #1;
        act_rdy_pre = push_ready_o;
        exp_rdy_pre = (q.size() < DEPTH);
        exp_upd = '0;
        exp_err = 1'b0;
        if (rst_i) begin
            q.delete();
        end else begin
            clr = fl;
            if (rv) begin
                if (q.size() == 0) begin
                    exp_err = 1'b1;
                end else if (q[0].pc == rpc) begin
                    e = q.pop_front();
                    exp_upd = {~dbg, e.pc, rt, e.meta};
                    if (rm) clr = 1'b1;
                end else begin
                    exp_err = 1'b1;
                    clr = 1'b1;
                end
            end
            if (clr) q.delete();
            else if (pv && exp_rdy_pre) q.push_back('{pc: ppc, meta: pm});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [31:0] pc, input logic [3:0] m);
        cycle(1, pc, m, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (count_o !== 4'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        vectors++; if (push_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", push_ready_o); end
        vectors++; if (bht_update_o !== 38'd0) begin fails++; $display("FAIL reset_update got=%h exp=0", bht_update_o); end
        vectors++; if (error_o !== 1'b0) begin fails++; $display("FAIL reset_error got=%b exp=0", error_o); end
    endtask

    task automatic test_basic();
        logic [31:0] pcs [3];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        do_reset();
        for (int i = 0; i < 3; i++) push(pcs[i], 4'b1110);
        cycle(0, 0, 0, 1, 32'h100, 1, 0, 0, 0);
        vectors++; if (bht_update_o !== exp_upd) begin fails++; $display("FAIL basic_update got=%h exp=%h", bht_update_o, exp_upd); end
        vectors++; if (bht_update_o[37] !== 1'b1 || bht_update_o[36:5] !== 32'h100 || bht_update_o[2] !== 1'b1)
            begin fails++; $display("FAIL basic_fields got=%h exp valid=1 pc=100 lbp_taken=1", bht_update_o); end
        vectors++; if (count_o !== 4'd2) begin fails++; $display("FAIL basic_count got=%0d exp=2", count_o); end
        idle();
        vectors++; if (bht_update_o[37] !== 1'b0) begin fails++; $display("FAIL basic_pulse got=%b exp=0", bht_update_o[37]); end
        for (int i = 1; i < 3; i++) begin
            cycle(0, 0, 0, 1, pcs[i], i[0], 0, 0, 0);
            vectors++; if (bht_update_o !== exp_upd) begin fails++; $display("FAIL basic_drain%0d got=%h exp=%h", i, bht_update_o, exp_upd); end
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i * 4), 4'(i));
        vectors++; if (push_ready_o !== 1'b0) begin fails++; $display("FAIL full_ready got=%b exp=0", push_ready_o); end
        cycle(1, 32'h2000, 4'hf, 1, 32'h1000, 0, 0, 0, 0);
        vectors++; if (act_rdy_pre !== 1'b0) begin fails++; $display("FAIL full_ready_same got=%b exp=0", act_rdy_pre); end
        vectors++; if (count_o !== 4'd7) begin fails++; $display("FAIL full_count got=%0d exp=7", count_o); end
        vectors++; if (bht_update_o !== exp_upd) begin fails++; $display("FAIL full_update got=%h exp=%h", bht_update_o, exp_upd); end
        vectors++; if (push_ready_o !== 1'b1) begin fails++; $display("FAIL full_ready_next got=%b exp=1", push_ready_o); end
    endtask

    task automatic test_empty_resolve();
        do_reset();
        cycle(0, 0, 0, 1, 32'h300, 1, 0, 0, 0);
        vectors++; if (error_o !== 1'b1) begin fails++; $display("FAIL empty_error got=%b exp=1", error_o); end
        vectors++; if (bht_update_o[37] !== 1'b0) begin fails++; $display("FAIL empty_valid got=%b exp=0", bht_update_o[37]); end
        vectors++; if (count_o !== 4'd0) begin fails++; $display("FAIL empty_count got=%0d exp=0", count_o); end
        idle();
        vectors++; if (error_o !== 1'b0) begin fails++; $display("FAIL empty_error_pulse got=%b exp=0", error_o); end
    endtask

    task automatic test_mispred();
        do_reset();
        for (int i = 0; i < 4; i++) push(32'h400 + 32'(i * 4), 4'b1011);
        cycle(1, 32'h500, 4'h1, 1, 32'h400, 1, 1, 0, 0);
        vectors++; if (bht_update_o !== exp_upd || bht_update_o[37] !== 1'b1)
            begin fails++; $display("FAIL mispred_update got=%h exp=%h", bht_update_o, exp_upd); end
        vectors++; if (count_o !== 4'd0) begin fails++; $display("FAIL mispred_count got=%0d exp=0", count_o); end
        cycle(0, 0, 0, 1, 32'h500, 0, 0, 0, 0);
        vectors++; if (error_o !== 1'b1) begin fails++; $display("FAIL mispred_dropped_push got=%b exp=1", error_o); end
    endtask

    task automatic test_mismatch();
        do_reset();
        push(32'h100, 4'b1100);
        push(32'h104, 4'b0011);
        cycle(0, 0, 0, 1, 32'h200, 1, 0, 0, 0);
        vectors++; if (error_o !== 1'b1) begin fails++; $display("FAIL mismatch_error got=%b exp=1", error_o); end
        vectors++; if (bht_update_o !== 38'd0) begin fails++; $display("FAIL mismatch_update got=%h exp=0", bht_update_o); end
        vectors++; if (count_o !== 4'd0) begin fails++; $display("FAIL mismatch_count got=%0d exp=0", count_o); end
    endtask

    task automatic test_flush();
        do_reset();
        push(32'h600, 4'b0101);
        push(32'h604, 4'b1010);
        cycle(1, 32'h608, 4'h3, 1, 32'h600, 0, 0, 1, 0);
        vectors++; if (bht_update_o !== exp_upd || bht_update_o[37] !== 1'b1)
            begin fails++; $display("FAIL flush_update got=%h exp=%h", bht_update_o, exp_upd); end
        vectors++; if (count_o !== 4'd0) begin fails++; $display("FAIL flush_count got=%0d exp=0", count_o); end
    endtask

    task automatic test_debug();
        do_reset();
        push(32'h700, 4'b1111);
        push(32'h704, 4'b0000);
        push(32'h708, 4'b0110);
        cycle(0, 0, 0, 1, 32'h700, 1, 0, 0, 1);
        vectors++; if (bht_update_o[37] !== 1'b0 || bht_update_o !== exp_upd)
            begin fails++; $display("FAIL debug_update got=%h exp=%h", bht_update_o, exp_upd); end
        vectors++; if (count_o !== 4'd2) begin fails++; $display("FAIL debug_count got=%0d exp=2", count_o); end
        rst_i = 1'b1;
        cycle(1, 32'h70c, 4'h1, 1, 32'h704, 1, 0, 0, 0);
        rst_i = 1'b0;
        vectors++; if (count_o !== 4'd0) begin fails++; $display("FAIL midreset_count got=%0d exp=0", count_o); end
        vectors++; if (push_ready_o !== 1'b1) begin fails++; $display("FAIL midreset_ready got=%b exp=1", push_ready_o); end
        vectors++; if (bht_update_o !== 38'd0 || error_o !== 1'b0)
            begin fails++; $display("FAIL midreset_outputs got=%h/%b exp=0/0", bht_update_o, error_o); end
    endtask

    task automatic test_random();
        logic [31:0] next_pc;
        logic [31:0] rpc;
        logic        rv;
        do_reset();
        next_pc = 32'h8000;
        for (int n = 0; n < 1500; n++) begin
            rv = ($urandom_range(0, 99) < 45);
            if (q.size() != 0 && $urandom_range(0, 9) < 8) rpc = q[0].pc;
            else rpc = 32'h9000 + 32'($urandom_range(0, 15) * 4);
            cycle(($urandom_range(0, 99) < 60), next_pc, 4'($urandom),
                  rv, rpc, 1'($urandom), ($urandom_range(0, 99) < 8),
                  ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 10));
            next_pc = next_pc + 32'd4;
            vectors++; if (act_rdy_pre !== exp_rdy_pre) begin fails++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, act_rdy_pre, exp_rdy_pre); end
            vectors++; if (bht_update_o !== exp_upd) begin fails++; $display("FAIL rnd_update n=%0d got=%h exp=%h", n, bht_update_o, exp_upd); end
            vectors++; if (error_o !== exp_err) begin fails++; $display("FAIL rnd_error n=%0d got=%b exp=%b", n, error_o, exp_err); end
            vectors++; if (count_o !== 4'(q.size())) begin fails++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count_o, q.size()); end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        flush_i = 0; debug_mode_i = 0; push_valid_i = 0; push_pc_i = 0; push_metadata_i = 0;
        resolve_valid_i = 0; resolve_pc_i = 0; resolve_taken_i = 0; resolve_mispred_i = 0;
        test_reset();
        test_basic();
        test_full();
        test_empty_resolve();
        test_mispred();
        test_mismatch();
        test_flush();
        test_debug();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
